// File: rtl/bp_cce_inst_stall_tracker_if.sv
// rtl/bp_cce_inst_stall_tracker_if.sv - instruction-side stall inputs of the CCE stall tracker
interface bp_cce_inst_stall_tracker_if #(
    parameter int num_rx_p  = 4,
    parameter int num_tx_p  = 2,
    parameter int num_haz_p = 5
);
    logic [num_rx_p-1:0]  rx_yumi_i;
    logic [num_rx_p-1:0]  rx_v_i;
    logic [num_tx_p-1:0]  tx_v_i;
    logic [num_tx_p-1:0]  tx_ready_i;
    logic                 wfq_v_i;
    logic [num_rx_p-1:0]  wfq_mask_i;
    logic [num_haz_p-1:0] haz_req_i;
    logic [num_haz_p-1:0] haz_busy_i;
    logic                 dir_busy_i;
    logic                 clr_cnt_i;

    modport master (
        output rx_yumi_i, rx_v_i, tx_v_i, tx_ready_i, wfq_v_i, wfq_mask_i,
               haz_req_i, haz_busy_i, dir_busy_i, clr_cnt_i
    );

    modport slave (
        input  rx_yumi_i, rx_v_i, tx_v_i, tx_ready_i, wfq_v_i, wfq_mask_i,
               haz_req_i, haz_busy_i, dir_busy_i, clr_cnt_i
    );
endinterface

// File: rtl/bp_cce_inst_stall_tracker.sv
// rtl/bp_cce_inst_stall_tracker.sv - CCE instruction stall decode with perf counters and watchdog
module bp_cce_inst_stall_tracker #(
    parameter int num_rx_p    = 4,
    parameter int num_tx_p    = 2,
    parameter int num_haz_p   = 5,
    parameter int cnt_width_p = 16,
    parameter int timeout_p   = 1024
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    bp_cce_inst_stall_tracker_if.slave ctl,
    output logic                       stall_o,
    output logic [4:0]                 stall_cause_o,
    output logic [cnt_width_p-1:0]     stall_count_o,
    output logic [5*cnt_width_p-1:0]   cause_count_o,
    output logic [cnt_width_p-1:0]     stall_run_o,
    output logic                       timeout_o,
    output logic [4:0]                 timeout_cause_o
);
    localparam logic [cnt_width_p-1:0] cnt_max_lp  = '1;
    localparam logic [cnt_width_p-1:0] cnt_one_lp  = cnt_width_p'(1);
    localparam logic [cnt_width_p-1:0] trip_run_lp = cnt_width_p'(timeout_p - 1);

    typedef enum logic {
        wd_idle,
        wd_tripped
    } wd_state_e;

    wd_state_e              wd_state;
    logic [cnt_width_p-1:0] cause_cnt_r [5];
    logic                   clear;

    // Cause bits are pure functions of the current instruction; nothing registered gates them.
    assign stall_cause_o[0] = |(ctl.rx_yumi_i & ~ctl.rx_v_i);
    assign stall_cause_o[1] = |(ctl.tx_v_i & ~ctl.tx_ready_i);
    assign stall_cause_o[2] = ctl.wfq_v_i & ~|(ctl.wfq_mask_i & ctl.rx_v_i);
    assign stall_cause_o[3] = |(ctl.haz_req_i & ctl.haz_busy_i);
    assign stall_cause_o[4] = ctl.dir_busy_i;
    assign stall_o          = |stall_cause_o;

    assign clear = reset_i | ctl.clr_cnt_i;

    always_ff @(posedge clk_i) begin
        if (clear) begin
            stall_count_o <= '0;
            stall_run_o   <= '0;
            for (int k = 0; k < 5; k++) cause_cnt_r[k] <= '0;
        end else begin
            if (stall_o && stall_count_o != cnt_max_lp)
                stall_count_o <= stall_count_o + cnt_one_lp;
            for (int k = 0; k < 5; k++)
                if (stall_cause_o[k] && cause_cnt_r[k] != cnt_max_lp)
                    cause_cnt_r[k] <= cause_cnt_r[k] + cnt_one_lp;
            if (!stall_o)
                stall_run_o <= '0;
            else if (stall_run_o != cnt_max_lp)
                stall_run_o <= stall_run_o + cnt_one_lp;
        end
    end

    for (genvar k = 0; k < 5; k++) begin : g_cause_out
        assign cause_count_o[k*cnt_width_p +: cnt_width_p] = cause_cnt_r[k];
    end

    // Trips on the timeout_p-th consecutive stall; only a clear or reset re-arms it.
    always_ff @(posedge clk_i) begin
        if (clear) begin
            wd_state        <= wd_idle;
            timeout_o       <= 1'b0;
            timeout_cause_o <= '0;
        end else begin
            case (wd_state)
                wd_idle: begin
                    if (stall_o && stall_run_o == trip_run_lp) begin
                        wd_state        <= wd_tripped;
                        timeout_o       <= 1'b1;
                        timeout_cause_o <= stall_cause_o;
                    end
                end
                wd_tripped: begin
                    wd_state <= wd_tripped;
                end
                default: begin
                    wd_state        <= wd_idle;
                    timeout_o       <= 1'b0;
                    timeout_cause_o <= '0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_bp_cce_inst_stall_tracker.sv
// tb/tb_bp_cce_inst_stall_tracker.sv - scoreboard bench for bp_cce_inst_stall_tracker
module tb_bp_cce_inst_stall_tracker;
    localparam int NRX = 4;
    localparam int NTX = 2;
    localparam int NHZ = 5;
    localparam int CW  = 4;
    localparam int TO  = 8;
    localparam int MAXC = (1 << CW) - 1;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    bp_cce_inst_stall_tracker_if #(.num_rx_p(NRX), .num_tx_p(NTX), .num_haz_p(NHZ)) bus ();

    logic            stall;
    logic [4:0]      cause;
    logic [CW-1:0]   total;
    logic [5*CW-1:0] ccount;
    logic [CW-1:0]   run;
    logic            tout;
    logic [4:0]      tcause;

    bp_cce_inst_stall_tracker #(
        .num_rx_p(NRX), .num_tx_p(NTX), .num_haz_p(NHZ),
        .cnt_width_p(CW), .timeout_p(TO)
    ) dut (
        .clk_i(clk), .reset_i(reset), .ctl(bus.slave),
        .stall_o(stall), .stall_cause_o(cause), .stall_count_o(total),
        .cause_count_o(ccount), .stall_run_o(run), .timeout_o(tout),
        .timeout_cause_o(tcause)
    );

    typedef struct packed {
        logic            stall;
        logic [4:0]      cause;
        logic [CW-1:0]   total;
        logic [5*CW-1:0] cc;
        logic [CW-1:0]   run;
        logic            to;
        logic [4:0]      tc;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int checks = 0;
    int errors = 0;

    int m_total, m_run;
    int m_cc[5];
    bit m_to;
    bit [4:0] m_tc;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int sat(int v);
        return (v > MAXC) ? MAXC : v;
    endfunction

    function automatic bit [4:0] model_cause();
        bit [4:0] c = '0;
        bit any_ready = 0;
        for (int i = 0; i < NRX; i++) if (bus.rx_yumi_i[i] && !bus.rx_v_i[i]) c[0] = 1;
        for (int i = 0; i < NTX; i++) if (bus.tx_v_i[i] && !bus.tx_ready_i[i]) c[1] = 1;
        for (int i = 0; i < NRX; i++) if (bus.wfq_mask_i[i] && bus.rx_v_i[i]) any_ready = 1;
        c[2] = bus.wfq_v_i && !any_ready;
        for (int i = 0; i < NHZ; i++) if (bus.haz_req_i[i] && bus.haz_busy_i[i]) c[3] = 1;
        c[4] = bus.dir_busy_i;
        return c;
    endfunction

    task automatic step(int n = 1);
        repeat (n) begin
            exp_t x;
            bit [4:0] c;
            c = model_cause();
            x.stall = (c != 0);
            x.cause = c;
            x.total = CW'(m_total);
            for (int k = 0; k < 5; k++) x.cc[k*CW +: CW] = CW'(m_cc[k]);
            x.run = CW'(sat(m_run));
            x.to = m_to;
            x.tc = m_tc;
            q.push_back(x);
            @(posedge clk);
            if (reset || bus.clr_cnt_i) begin
                m_total = 0; m_run = 0; m_to = 0; m_tc = 0;
                for (int k = 0; k < 5; k++) m_cc[k] = 0;
            end else if (c != 0) begin
                m_total = sat(m_total + 1);
                for (int k = 0; k < 5; k++) if (c[k]) m_cc[k] = sat(m_cc[k] + 1);
                m_run++;
                if (!m_to && m_run == TO) begin
                    m_to = 1;
                    m_tc = c;
                end
            end else begin
                m_run = 0;
            end
            #1;
        end
    endtask

    task automatic idle_inputs();
        bus.rx_yumi_i = '0; bus.rx_v_i = '0; bus.tx_v_i = '0; bus.tx_ready_i = '0;
        bus.wfq_v_i = 0; bus.wfq_mask_i = '0; bus.haz_req_i = '0; bus.haz_busy_i = '0;
        bus.dir_busy_i = 0; bus.clr_cnt_i = 0;
    endtask

    always @(negedge clk) begin
        if (q.size() != 0) begin
            e = q.pop_front();
            chk("stall_o", 32'(stall), 32'(e.stall));
            chk("stall_cause_o", 32'(cause), 32'(e.cause));
            chk("stall_count_o", 32'(total), 32'(e.total));
            chk("cause_count_o", 32'(ccount), 32'(e.cc));
            chk("stall_run_o", 32'(run), 32'(e.run));
            chk("timeout_o", 32'(tout), 32'(e.to));
            chk("timeout_cause_o", 32'(tcause), 32'(e.tc));
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1, "bench did not finish");
    end

    initial begin
        m_total = 0; m_run = 0; m_to = 0; m_tc = 0;
        for (int k = 0; k < 5; k++) m_cc[k] = 0;
        idle_inputs();
        reset = 1;
        repeat (2) @(posedge clk);
        #1;
        reset = 0;
        step(1);

        // queue valid gating
        bus.rx_yumi_i = 4'b0010;
        step(3);
        bus.rx_v_i = 4'b0010;
        step(1);
        idle_inputs();
        step(2);

        // overlapping tx + dir
        bus.clr_cnt_i = 1; step(1); bus.clr_cnt_i = 0;
        bus.tx_v_i = 2'b01; bus.dir_busy_i = 1;
        step(1);
        idle_inputs();
        step(2);

        // watchdog trip on wfq with empty mask
        bus.clr_cnt_i = 1; step(1); bus.clr_cnt_i = 0;
        bus.wfq_v_i = 1;
        step(10);
        idle_inputs();
        step(2);
        bus.clr_cnt_i = 1; step(1); bus.clr_cnt_i = 0;
        step(2);

        // saturation
        bus.haz_req_i = 5'b00001; bus.haz_busy_i = 5'b00001;
        step(20);
        idle_inputs();
        step(2);

        // clear colliding with a stall
        bus.clr_cnt_i = 1; step(1); bus.clr_cnt_i = 0;
        bus.dir_busy_i = 1;
        step(5);
        bus.clr_cnt_i = 1; step(1); bus.clr_cnt_i = 0;
        step(1);
        idle_inputs();
        step(2);

        // reset during a stall with the watchdog tripped
        bus.clr_cnt_i = 1; step(1); bus.clr_cnt_i = 0;
        bus.wfq_v_i = 1; bus.wfq_mask_i = 4'b0100;
        step(9);
        reset = 1; step(1); reset = 0;
        step(3);
        idle_inputs();
        step(2);

        // randomized traffic
        for (int i = 0; i < 800; i++) begin
            idle_inputs();
            if ($urandom_range(3) != 0) begin
                bus.rx_v_i     = NRX'($urandom);
                bus.rx_yumi_i  = NRX'($urandom) & NRX'($urandom);
                bus.tx_v_i     = NTX'($urandom) & NTX'($urandom);
                bus.tx_ready_i = NTX'($urandom);
                bus.wfq_v_i    = ($urandom_range(5) == 0);
                bus.wfq_mask_i = NRX'($urandom);
                bus.haz_req_i  = NHZ'($urandom) & NHZ'($urandom);
                bus.haz_busy_i = NHZ'($urandom) & NHZ'($urandom);
                bus.dir_busy_i = ($urandom_range(4) == 0);
            end
            bus.clr_cnt_i = ($urandom_range(40) == 0);
            reset = ($urandom_range(150) == 0);
            step(1);
        end
        reset = 0;
        idle_inputs();
        step(2);

        @(negedge clk);
        #1;
        chk("scoreboard_drained", 32'(q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
